// File: rtl/road_request_encoder.sv
// Sensor front end: turns per-road detector pulses and sirens into one-hot Emergency/Jam/Empty requests.
// Define EMERG_TIMEOUT_EN to add an emergency hold timeout with per-road lockout until the siren drops.
module road_request_encoder #(
    parameter int QW      = 5,
    parameter int JAM_TH  = 12,
    parameter int DEB     = 3,
    parameter int JAM_GAP = 40
`ifdef EMERG_TIMEOUT_EN
    ,
    parameter int EMERG_MAX = 200
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      arrive,
    input  logic [3:0]      depart,
    input  logic [3:0]      siren,
    input  logic [3:0]      lamp_green,
    output logic [3:0]      Emergency,
    output logic [3:0]      Jam,
    output logic [3:0]      Empty,
    output logic [4*QW-1:0] queue_cnt
);
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int CW = $clog2(JAM_GAP + 1);

    typedef enum logic {S_IDLE, S_HOLD} emerg_state_t;

    logic [QW-1:0] r_cnt [4];
    logic [DW-1:0] r_deb [4];
    logic [3:0]    r_sir_ok;
    emerg_state_t  r_state;
    logic [1:0]    r_owner;
    logic [CW-1:0] r_cool;
    logic [1:0]    r_ptr;

    logic [3:0]    w_jammed;
    logic [3:0]    w_zero;
    logic [3:0]    w_elig;
    logic [1:0]    w_grant_idx;
    logic          w_jam_found;
    logic [1:0]    w_jam_idx;
    logic          w_jam_issue;
    logic          w_lamp_onehot;

    assign queue_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_jammed[i] = (r_cnt[i] >= QW'(JAM_TH));
            w_zero[i]   = (r_cnt[i] == '0);
        end
    end

`ifdef EMERG_TIMEOUT_EN
    localparam int HW = (EMERG_MAX > 1) ? $clog2(EMERG_MAX) : 1;
    logic [HW-1:0] r_hold;
    logic [3:0]    r_lock;
    logic          w_timeout;
    logic [3:0]    w_lock_set;

    assign w_timeout  = (r_state == S_HOLD) && r_sir_ok[r_owner] && (r_hold == HW'(EMERG_MAX - 1));
    assign w_lock_set = w_timeout ? (4'b0001 << r_owner) : 4'b0000;
    assign w_elig     = r_sir_ok & ~r_lock;

    // A timed-out road stays locked until its raw siren is seen low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock <= '0;
        end else begin
            r_lock <= (r_lock | w_lock_set) & siren;
        end
    end
`else
    assign w_elig = r_sir_ok;
`endif

    // Highest index wins: east > north > west > south.
    always_comb begin
        w_grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_elig[i]) w_grant_idx = 2'(i);
        end
    end

    // Round-robin walks east -> north -> west -> south, i.e. descending index with wrap.
    always_comb begin
        w_jam_found = 1'b0;
        w_jam_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_jam_found && w_jammed[r_ptr - 2'(k)]) begin
                w_jam_found = 1'b1;
                w_jam_idx   = r_ptr - 2'(k);
            end
        end
    end

    assign w_jam_issue   = w_jam_found && (Emergency == 4'b0000) && (r_cool == '0);
    assign w_lamp_onehot = (lamp_green != 4'b0000) && ((lamp_green & (lamp_green - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
                r_deb[i] <= '0;
            end
            r_sir_ok <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case ({arrive[i], depart[i]})
                    2'b10:   if (r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: ;
                endcase
                if (!siren[i]) begin
                    r_deb[i]    <= '0;
                    r_sir_ok[i] <= 1'b0;
                end else if (r_deb[i] == DW'(DEB - 1)) begin
                    r_sir_ok[i] <= 1'b1;
                end else begin
                    r_deb[i] <= r_deb[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_owner   <= 2'd0;
            Emergency <= 4'b0000;
`ifdef EMERG_TIMEOUT_EN
            r_hold    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_elig) begin
                        r_state   <= S_HOLD;
                        r_owner   <= w_grant_idx;
                        Emergency <= 4'b0001 << w_grant_idx;
`ifdef EMERG_TIMEOUT_EN
                        r_hold    <= '0;
`endif
                    end else begin
                        Emergency <= 4'b0000;
                    end
                end
                S_HOLD: begin
                    if (!r_sir_ok[r_owner]) begin
                        r_state   <= S_IDLE;
                        Emergency <= 4'b0000;
                    end
`ifdef EMERG_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state   <= S_IDLE;
                        Emergency <= 4'b0000;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Jam    <= 4'b0000;
            r_cool <= '0;
            r_ptr  <= 2'd3;
            Empty  <= 4'b0000;
        end else begin
            if (w_jam_issue) begin
                Jam    <= 4'b0001 << w_jam_idx;
                r_cool <= CW'(JAM_GAP);
                r_ptr  <= w_jam_idx - 2'd1;
            end else begin
                Jam <= 4'b0000;
                if (r_cool != '0) r_cool <= r_cool - 1'b1;
            end
            if (w_lamp_onehot && (Emergency == 4'b0000) && !w_jam_issue) begin
                Empty <= lamp_green & w_zero;
            end else begin
                Empty <= 4'b0000;
            end
        end
    end
endmodule

// File: tb/tb_road_request_encoder.sv
// Bench for road_request_encoder: directed scenarios then random traffic, checked against a road-level model.
module tb_road_request_encoder;
    localparam int QW        = 5;
    localparam int QMAX      = 31;
    localparam int JAM_TH    = 12;
    localparam int DEB       = 3;
    localparam int JAM_GAP   = 40;
    localparam int EMERG_MAX = 200;

    logic        clk;
    logic        rst;
    logic [3:0]  arrive, depart, siren, lamp_green;
    logic [3:0]  Emergency, Jam, Empty;
    logic [19:0] queue_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Road-level reference state; roads are 0..3 with 3 = east.
    int         m_q [4];
    int         m_streak [4];
    bit         m_ok [4];
    bit         m_lock [4];
    int         m_owner;
    int         m_shown;
    int         m_cool;
    int         m_pos;
    logic [3:0] m_em, m_jam, m_empty;

    road_request_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .arrive    (arrive),
        .depart    (depart),
        .siren     (siren),
        .lamp_green(lamp_green),
        .Emergency (Emergency),
        .Jam       (Jam),
        .Empty     (Empty),
        .queue_cnt (queue_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++) begin
            m_q[r] = 0; m_streak[r] = 0; m_ok[r] = 0; m_lock[r] = 0;
        end
        m_owner = -1; m_shown = 0; m_cool = 0; m_pos = 0;
        m_em = 4'b0000; m_jam = 4'b0000; m_empty = 4'b0000;
    endtask

    task automatic model_step();
        int         oq [4];
        bit         ook [4];
        logic [3:0] old_em;
        logic [3:0] zero;
        int         pick;
        int         newpos;
        for (int r = 0; r < 4; r++) begin
            oq[r]   = m_q[r];
            ook[r]  = m_ok[r];
            zero[r] = (m_q[r] == 0);
        end
        old_em = m_em;
        if (m_owner < 0) begin
            pick = -1;
            for (int r = 3; r >= 0; r--) if (pick < 0 && ook[r] && !m_lock[r]) pick = r;
            if (pick >= 0) begin
                m_owner = pick; m_shown = 1; m_em = 4'b0001 << pick;
            end else begin
                m_em = 4'b0000;
            end
        end
        else if (!ook[m_owner]) begin
            m_owner = -1; m_em = 4'b0000;
        end
`ifdef EMERG_TIMEOUT_EN
        else if (m_shown >= EMERG_MAX) begin
            m_lock[m_owner] = 1; m_owner = -1; m_em = 4'b0000;
        end
        else m_shown++;
`endif
        for (int r = 0; r < 4; r++) if (!siren[r]) m_lock[r] = 0;
        // Jam order list position p maps to road 3-p (east first).
        pick = -1; newpos = m_pos;
        if (old_em == 4'b0000 && m_cool == 0) begin
            for (int k = 0; k < 4; k++) begin
                int p;
                p = (m_pos + k) % 4;
                if (pick < 0 && oq[3 - p] >= JAM_TH) begin
                    pick = 3 - p; newpos = (p + 1) % 4;
                end
            end
        end
        m_pos = newpos;
        if (pick >= 0) begin
            m_jam = 4'b0001 << pick; m_cool = JAM_GAP;
        end else begin
            m_jam = 4'b0000;
            if (m_cool > 0) m_cool--;
        end
        if ($countones(lamp_green) == 1 && old_em == 4'b0000 && m_jam == 4'b0000) m_empty = lamp_green & zero;
        else m_empty = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (siren[r]) begin
                if (m_streak[r] < 1000) m_streak[r]++;
                m_ok[r] = (m_streak[r] >= DEB);
            end else begin
                m_streak[r] = 0; m_ok[r] = 0;
            end
            if (arrive[r] && !depart[r] && m_q[r] < QMAX) m_q[r]++;
            if (depart[r] && !arrive[r] && m_q[r] > 0) m_q[r]--;
        end
    endtask

    task automatic check_all();
        logic [19:0] exp_q;
        for (int r = 0; r < 4; r++) exp_q[r*QW +: QW] = 5'(m_q[r]);
        chk("emergency", 32'(Emergency), 32'(m_em));
        chk("jam", 32'(Jam), 32'(m_jam));
        chk("empty", 32'(Empty), 32'(m_empty));
        chk("queue_cnt", 32'(queue_cnt), 32'(exp_q));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] first_jam;
        logic [3:0] sir;
        int waited;
        int n_south;
        rst = 1'b1; arrive = '0; depart = '0; siren = '0; lamp_green = '0;
        #2;
        // Reset held while every road pulses arrive.
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        arrive = 4'b1111;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("count_after_release", 32'(queue_cnt), 32'({4{5'd1}}));
        arrive = '0;

        // Short siren is ignored; a debounced one is granted the edge after acceptance.
        do_reset();
        siren = 4'b0100; step(); step();
        siren = 4'b0000; repeat (3) step();
        chk("short_siren", 32'(Emergency), 32'h0);
        siren = 4'b0100; repeat (3) step();
        step();
        chk("north_grant", 32'(Emergency), 32'h4);
        siren = 4'b0000; step(); step();
        chk("north_release", 32'(Emergency), 32'h0);

        // East beats south, then south after a one-cycle gap.
        siren = 4'b1001; repeat (4) step();
        chk("east_first", 32'(Emergency), 32'h8);
        repeat (3) step();
        chk("east_held", 32'(Emergency), 32'h8);
        siren = 4'b0001; step(); step();
        chk("gap_cycle", 32'(Emergency), 32'h0);
        step();
        chk("south_next", 32'(Emergency), 32'h1);
        siren = 4'b0000; repeat (3) step();

        // Jam on west, cooldown, then east/west alternation.
        do_reset();
        arrive = 4'b0010; repeat (12) step();
        chk("west_count12", 32'(queue_cnt), 32'(20'd12 << 5));
        arrive = 4'b0000; step();
        chk("west_jam", 32'(Jam), 32'h2);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("jam_cooldown", 32'(Jam), 32'h0);
        end
        step();
        chk("west_jam_again", 32'(Jam), 32'h2);
        arrive = 4'b1000; repeat (12) step();
        arrive = 4'b0000;
        waited = 0;
        step();
        while (Jam == 4'b0000 && waited < 50) begin
            step();
            waited++;
        end
        chk("jam_seen", 32'(Jam != 4'b0000), 32'h1);
        first_jam = Jam;
        repeat (41) step();
        chk("jam_alternate", 32'(Jam), (first_jam == 4'b1000) ? 32'h2 : 32'h8);

        // Empty, arrive+depart at zero, saturation.
        depart = 4'b1010; repeat (20) step();
        depart = 4'b0000;
        lamp_green = 4'b0100; step();
        chk("empty_north", 32'(Empty), 32'h4);
        arrive = 4'b0100; step();
        arrive = 4'b0000; step();
        chk("empty_cleared", 32'(Empty), 32'h0);
        lamp_green = 4'b0110; depart = 4'b0100; step();
        depart = 4'b0000; step();
        chk("empty_not_onehot", 32'(Empty), 32'h0);
        arrive = 4'b0001; depart = 4'b0001; step();
        chk("arr_dep_zero", 32'(queue_cnt), 32'h0);
        depart = 4'b0000; repeat (33) step();
        chk("saturate", 32'(queue_cnt[4:0]), 32'd31);
        arrive = 4'b0000; lamp_green = 4'b0000;

`ifdef EMERG_TIMEOUT_EN
        do_reset();
        siren = 4'b0001; repeat (4) step();
        siren = 4'b1001;
        n_south = 0;
        repeat (250) begin
            step();
            if (Emergency == 4'b0001) n_south++;
        end
        chk("south_timeout", 32'(n_south), 32'd199);
        chk("east_after_timeout", 32'(Emergency), 32'h8);
        siren = 4'b0001; repeat (4) step();
        chk("south_locked", 32'(Emergency), 32'h0);
        siren = 4'b0000; step();
`else
        n_south = 0;
`endif

        // Random traffic with a reset in the middle.
        do_reset();
        sir = 4'b0000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                do_reset();
            end
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 19) == 0) sir[b] = ~sir[b];
            siren = sir;
            if ((cyc % 1000) < 600) begin
                arrive = 4'($urandom) | (4'($urandom) & 4'($urandom));
                depart = 4'($urandom) & 4'($urandom);
            end else begin
                arrive = 4'($urandom) & 4'($urandom);
                depart = 4'($urandom) | 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) lamp_green = 4'($urandom_range(0, 15));
            else lamp_green = 4'b0001 << $urandom_range(0, 3);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
